hazard_track_pipe: RTL and testbench
====================================

// Module: hazard_track_pipe
// PURPOSE
//  Holds the E/M/W pipeline copies of register addresses and hazard control bits, and produces the
//  compare/qualified-control inputs the hazard unit consumes: Match_*, RegWriteM/W, MemtoRegE,
//  PCSrcE/M/W, BranchTakenE. Sits between decode/condition logic and the hazard unit.
//  Applies FlushE back from the hazard unit and keeps saturating stall/flush event counters for debug.
// PARAMETERS
//  ADDR_W  4   register-index width
//  PC_REG  15  index of PC; never reported as a match, and the reset/flush value of every held address
//  CNT_W   16  width of debug event counters
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       asynchronous, active-low reset
//  RA1D,RA2D     in   ADDR_W  decode-stage source indices
//  WA3D          in   ADDR_W  decode-stage destination index
//  RegWriteD     in   1       decode control: writes register
//  MemtoRegD     in   1       decode control: load
//  PCSrcD        in   1       decode control: writes PC
//  BranchD       in   1       decode control: branch
//  CondExE       in   1       condition passed for instruction in E (combinational from E-stage flags)
//  FlushE        in   1       from hazard unit: bubble E next edge
//  StallD        in   1       from hazard unit: counted only
//  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E  out 1  address compares
//  RegWriteM,RegWriteW,MemtoRegE,PCSrcE,PCSrcM,PCSrcW,BranchTakenE out 1  qualified control
//  RA1E,RA2E,WA3E,WA3M,WA3W  out  ADDR_W  held indices
//  LdStallCnt,FlushCnt       out  CNT_W   debug counters
// BEHAVIOUR
//  - Reset (async, reset==0): all held indices = PC_REG; all control flops = 0; counters = 0.
//    Consequence: every Match_* and every control output is 0 while in/after reset.
//  - E register, each edge: FlushE=1 -> indices <= PC_REG, RegWriteE/MemtoRegE/PCSrcE_r/BranchE <= 0;
//    else load RA1D,RA2D,WA3D and D controls. FlushE wins over any D-stage content.
//  - Condition qualification (combinational in E): PCSrcE = PCSrcE_r & CondExE; BranchTakenE =
//    BranchE & CondExE; MemtoRegE output is unqualified (load-use must stall regardless of cond).
//  - M register: WA3M<=WA3E; RegWriteM<=RegWriteE&CondExE; PCSrcM<=PCSrcE; MemtoRegM<=MemtoRegE&CondExE.
//  - W register: WA3W<=WA3M; RegWriteW<=RegWriteM; PCSrcW<=PCSrcM. M and W never stall or flush.
//  - Latency: a D-stage op appears in E after 1 edge, M after 2, W after 3.
//  - Matches (combinational, ADDR_W-bit equality): Match_1E_M=(RA1E==WA3M), Match_1E_W=(RA1E==WA3W),
//    Match_2E_M/W likewise with RA2E, Match_12D_E=(RA1D==WA3E)|(RA2D==WA3E).
//    Any compare whose held destination equals PC_REG is forced 0 (PC is never forwarded).
//  - Matches are not gated by RegWrite; the hazard unit qualifies them.
//  - Counters: LdStallCnt +1 on edges with StallD=1; FlushCnt +1 on edges with FlushE=1; both
//    saturate at all-ones (no wrap). Reset mid-count clears to 0 immediately.
//  - Reset asserted mid-pipeline discards all in-flight ops; no partial state survives.
// STRUCTURE
//  - Shared package hazard_pkg: ADDR_W, PC_REG, forward-select encodings (00 RF, 01 ResultW, 10 ALUOutM).
//  - One sub-module: pipe_flop_clr #(W, RST_VAL) - async-reset flop with sync clear-to-RST_VAL,
//    instantiated for E indices/controls (clear=FlushE) and for M/W (clear tied 0).
//  - Match logic and counters stay inline.
// TESTING
//  1 reset low 3 cycles, D inputs random -> all outputs 0, WA3E/M/W=15, counters 0.
//  2 D: WA3D=3,RegWriteD=1,CondExE=1; next op RA1D=3 -> after edge 2 Match_1E_M=1,RegWriteM=1;
//    edge 3 Match_1E_W=1,RegWriteW=1.
//  3 load WA3D=5,MemtoRegD=1 in E; RA2D=5 in D -> Match_12D_E=1, MemtoRegE=1; FlushE=1 next edge ->
//    WA3E=15, MemtoRegE=0, Match_12D_E=0, FlushCnt=1.
//  4 CondExE=0 with RegWriteE=1,PCSrcE_r=1,BranchE=1 -> PCSrcE=0,BranchTakenE=0; next edge RegWriteM=0,PCSrcM=0.
//  5 WA3D=15,RegWriteD=1; RA1D=15 follows -> Match_12D_E=0 and Match_1E_M=0 throughout.
//  6 force LdStallCnt to 16'hFFFE, StallD=1 for 3 edges -> 16'hFFFF, holds; reset low -> 0 asynchronously.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard tracking pipeline and the hazard unit it feeds.
package hazard_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned PC_REG = 15;
   localparam int unsigned CNT_W  = 16;

   // Forwarding mux select as decoded by the hazard unit.
   typedef enum logic [1:0] {
      FwdRf      = 2'b00,
      FwdResultW = 2'b01,
      FwdAluOutM = 2'b10
   } fwd_sel_e;

   // E-stage control bits; pc_src and branch are still unqualified by the condition here.
   typedef struct packed {
      logic reg_write;
      logic memto_reg;
      logic pc_src;
      logic branch;
   } ctrl_e_t;

endpackage

// File: rtl/pipe_flop_clr.sv
// Pipeline register: asynchronous reset and synchronous clear, both loading RST_VAL.
module pipe_flop_clr #(
   parameter int unsigned  W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = clr_i ? RST_VAL : d_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/hazard_track_pipe.sv
// E/M/W copies of register indices and hazard controls, address compares for the hazard unit,
// and saturating stall/flush debug counters.
module hazard_track_pipe
   import hazard_pkg::ctrl_e_t;
#(
   parameter int unsigned ADDR_W = hazard_pkg::ADDR_W,
   parameter int unsigned PC_REG = hazard_pkg::PC_REG,
   parameter int unsigned CNT_W  = hazard_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RA1D,
   input  logic [ADDR_W-1:0] RA2D,
   input  logic [ADDR_W-1:0] WA3D,
   input  logic              RegWriteD,
   input  logic              MemtoRegD,
   input  logic              PCSrcD,
   input  logic              BranchD,
   input  logic              CondExE,
   input  logic              FlushE,
   input  logic              StallD,
   output logic              Match_1E_M,
   output logic              Match_1E_W,
   output logic              Match_2E_M,
   output logic              Match_2E_W,
   output logic              Match_12D_E,
   output logic              RegWriteM,
   output logic              RegWriteW,
   output logic              MemtoRegE,
   output logic              PCSrcE,
   output logic              PCSrcM,
   output logic              PCSrcW,
   output logic              BranchTakenE,
   output logic [ADDR_W-1:0] RA1E,
   output logic [ADDR_W-1:0] RA2E,
   output logic [ADDR_W-1:0] WA3E,
   output logic [ADDR_W-1:0] WA3M,
   output logic [ADDR_W-1:0] WA3W,
   output logic [CNT_W-1:0]  LdStallCnt,
   output logic [CNT_W-1:0]  FlushCnt
);

   localparam logic [ADDR_W-1:0] PcIdx = ADDR_W'(PC_REG);

   ctrl_e_t ctrl_d, ctrl_e;
   logic    reg_write_m_d, pc_src_m_d;

   always_comb begin
      ctrl_d.reg_write = RegWriteD;
      ctrl_d.memto_reg = MemtoRegD;
      ctrl_d.pc_src    = PCSrcD;
      ctrl_d.branch    = BranchD;
   end

   // ---------------- E stage: bubbled by FlushE ----------------
   pipe_flop_clr #(
      .W       (3 * ADDR_W),
      .RST_VAL ({PcIdx, PcIdx, PcIdx})
   ) u_e_idx (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (FlushE),
      .d_i    ({RA1D, RA2D, WA3D}),
      .q_o    ({RA1E, RA2E, WA3E})
   );

   pipe_flop_clr #(
      .W       ($bits(ctrl_e_t)),
      .RST_VAL ('0)
   ) u_e_ctrl (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (FlushE),
      .d_i    (ctrl_d),
      .q_o    (ctrl_e)
   );

   // Load-use detection needs MemtoRegE regardless of whether the condition passes.
   assign MemtoRegE    = ctrl_e.memto_reg;
   assign PCSrcE       = ctrl_e.pc_src & CondExE;
   assign BranchTakenE = ctrl_e.branch & CondExE;

   always_comb begin
      reg_write_m_d = ctrl_e.reg_write & CondExE;
      pc_src_m_d    = PCSrcE;
   end

   // ---------------- M and W stages: never stalled or flushed ----------------
   pipe_flop_clr #(
      .W       (ADDR_W + 2),
      .RST_VAL ({PcIdx, 2'b00})
   ) u_m (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (1'b0),
      .d_i    ({WA3E, reg_write_m_d, pc_src_m_d}),
      .q_o    ({WA3M, RegWriteM, PCSrcM})
   );

   pipe_flop_clr #(
      .W       (ADDR_W + 2),
      .RST_VAL ({PcIdx, 2'b00})
   ) u_w (
      .clk_i  (clk),
      .rst_ni (reset),
      .clr_i  (1'b0),
      .d_i    ({WA3M, RegWriteM, PCSrcM}),
      .q_o    ({WA3W, RegWriteW, PCSrcW})
   );

   // ---------------- Address compares; PC is never forwarded ----------------
   logic wa3e_pc, wa3m_pc, wa3w_pc;

   always_comb begin
      wa3e_pc     = (WA3E == PcIdx);
      wa3m_pc     = (WA3M == PcIdx);
      wa3w_pc     = (WA3W == PcIdx);
      Match_1E_M  = (RA1E == WA3M) & ~wa3m_pc;
      Match_1E_W  = (RA1E == WA3W) & ~wa3w_pc;
      Match_2E_M  = (RA2E == WA3M) & ~wa3m_pc;
      Match_2E_W  = (RA2E == WA3W) & ~wa3w_pc;
      Match_12D_E = ((RA1D == WA3E) | (RA2D == WA3E)) & ~wa3e_pc;
   end

   // ---------------- Saturating debug counters ----------------
   logic [CNT_W-1:0] ld_cnt_d, ld_cnt_q;
   logic [CNT_W-1:0] fl_cnt_d, fl_cnt_q;

   always_comb begin
      ld_cnt_d = ld_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (StallD && !(&ld_cnt_q)) begin
         ld_cnt_d = ld_cnt_q + CNT_W'(1);
      end
      if (FlushE && !(&fl_cnt_q)) begin
         fl_cnt_d = fl_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign LdStallCnt = ld_cnt_q;
   assign FlushCnt   = fl_cnt_q;

endmodule

// File: tb/tb_hazard_track_pipe.sv
// Self-checking bench: directed corner sequences plus a model-filled vector table
// whose expected outputs flow through a scoreboard queue.
module tb_hazard_track_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] RA1D, RA2D, WA3D;
   logic       RegWriteD, MemtoRegD, PCSrcD, BranchD, CondExE, FlushE, StallD;
   logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
   logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic [3:0] RA1E, RA2E, WA3E, WA3M, WA3W;
   logic [15:0] LdStallCnt, FlushCnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_track_pipe dut (
      .clk          (clk),
      .reset        (reset),
      .RA1D         (RA1D),
      .RA2D         (RA2D),
      .WA3D         (WA3D),
      .RegWriteD    (RegWriteD),
      .MemtoRegD    (MemtoRegD),
      .PCSrcD       (PCSrcD),
      .BranchD      (BranchD),
      .CondExE      (CondExE),
      .FlushE       (FlushE),
      .StallD       (StallD),
      .Match_1E_M   (Match_1E_M),
      .Match_1E_W   (Match_1E_W),
      .Match_2E_M   (Match_2E_M),
      .Match_2E_W   (Match_2E_W),
      .Match_12D_E  (Match_12D_E),
      .RegWriteM    (RegWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegE    (MemtoRegE),
      .PCSrcE       (PCSrcE),
      .PCSrcM       (PCSrcM),
      .PCSrcW       (PCSrcW),
      .BranchTakenE (BranchTakenE),
      .RA1E         (RA1E),
      .RA2E         (RA2E),
      .WA3E         (WA3E),
      .WA3M         (WA3M),
      .WA3W         (WA3W),
      .LdStallCnt   (LdStallCnt),
      .FlushCnt     (FlushCnt)
   );

   typedef struct packed {
      logic [3:0] ra1, ra2, wa3;
      logic       rw, m2r, pcs, br, cond, flush, stall;
   } in_t;

   typedef struct packed {
      logic [3:0]  ra1e, ra2e, wa3e, wa3m, wa3w;
      logic        m1em, m1ew, m2em, m2ew, m12de;
      logic        rwm, rww, m2re, pcse, pcsm, pcsw, bte;
      logic [15:0] ldc, flc;
   } outs_t;

   typedef struct packed {
      logic [3:0]  ra1e, ra2e, wa3e;
      logic        rwe, m2re, pcse, bre;
      logic [3:0]  wa3m;
      logic        rwm, pcsm;
      logic [3:0]  wa3w;
      logic        rww, pcsw;
      logic [15:0] ldc, flc;
   } st_t;

   typedef struct packed {
      in_t   i;
      outs_t e;
   } vec_t;

   outs_t act;
   assign act = {RA1E, RA2E, WA3E, WA3M, WA3W, Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
                 Match_12D_E, RegWriteM, RegWriteW, MemtoRegE, PCSrcE, PCSrcM, PCSrcW,
                 BranchTakenE, LdStallCnt, FlushCnt};

   function automatic st_t rst_state();
      st_t s;
      s = '0;
      s.ra1e = 4'd15; s.ra2e = 4'd15; s.wa3e = 4'd15; s.wa3m = 4'd15; s.wa3w = 4'd15;
      return s;
   endfunction

   function automatic st_t step(st_t s, in_t v);
      st_t n;
      n      = s;
      n.wa3w = s.wa3m; n.rww = s.rwm; n.pcsw = s.pcsm;
      n.wa3m = s.wa3e; n.rwm = s.rwe & v.cond; n.pcsm = s.pcse & v.cond;
      if (v.flush) begin
         n.ra1e = 4'd15; n.ra2e = 4'd15; n.wa3e = 4'd15;
         n.rwe = 1'b0; n.m2re = 1'b0; n.pcse = 1'b0; n.bre = 1'b0;
      end else begin
         n.ra1e = v.ra1; n.ra2e = v.ra2; n.wa3e = v.wa3;
         n.rwe = v.rw; n.m2re = v.m2r; n.pcse = v.pcs; n.bre = v.br;
      end
      if (v.stall && s.ldc != 16'hFFFF) n.ldc = s.ldc + 16'd1;
      if (v.flush && s.flc != 16'hFFFF) n.flc = s.flc + 16'd1;
      return n;
   endfunction

   function automatic outs_t model_out(st_t s, in_t v);
      outs_t o;
      o.ra1e = s.ra1e; o.ra2e = s.ra2e; o.wa3e = s.wa3e; o.wa3m = s.wa3m; o.wa3w = s.wa3w;
      o.m1em  = (s.ra1e == s.wa3m) && (s.wa3m != 4'd15);
      o.m1ew  = (s.ra1e == s.wa3w) && (s.wa3w != 4'd15);
      o.m2em  = (s.ra2e == s.wa3m) && (s.wa3m != 4'd15);
      o.m2ew  = (s.ra2e == s.wa3w) && (s.wa3w != 4'd15);
      o.m12de = ((v.ra1 == s.wa3e) || (v.ra2 == s.wa3e)) && (s.wa3e != 4'd15);
      o.rwm = s.rwm; o.rww = s.rww; o.m2re = s.m2re;
      o.pcse = s.pcse & v.cond; o.pcsm = s.pcsm; o.pcsw = s.pcsw; o.bte = s.bre & v.cond;
      o.ldc = s.ldc; o.flc = s.flc;
      return o;
   endfunction

   function automatic logic [3:0] rnd_idx();
      int unsigned r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 4'd15 : 4'(r);
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string name, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input in_t v);
      RA1D = v.ra1; RA2D = v.ra2; WA3D = v.wa3;
      RegWriteD = v.rw; MemtoRegD = v.m2r; PCSrcD = v.pcs; BranchD = v.br;
      CondExE = v.cond; FlushE = v.flush; StallD = v.stall;
   endtask

   task automatic set_d(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] wa,
                        input logic rw, input logic m2r, input logic pcs, input logic br);
      RA1D = a1; RA2D = a2; WA3D = wa;
      RegWriteD = rw; MemtoRegD = m2r; PCSrcD = pcs; BranchD = br;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam int NVec = 32;
   vec_t  vecs [NVec];
   outs_t exp_q [$];
   outs_t exp_o;

   initial begin
      st_t st;
      in_t v;

      // Fill the vector table from the reference model, starting at the reset state.
      st = rst_state();
      for (int k = 0; k < NVec; k++) begin
         v.ra1 = rnd_idx(); v.ra2 = rnd_idx(); v.wa3 = rnd_idx();
         v.rw = 1'($urandom); v.m2r = 1'($urandom); v.pcs = 1'($urandom); v.br = 1'($urandom);
         v.cond  = ($urandom_range(0, 3) != 0);
         v.flush = ($urandom_range(0, 4) == 0);
         v.stall = ($urandom_range(0, 2) == 0);
         st = step(st, v);
         vecs[k].i = v;
         vecs[k].e = model_out(st, v);
      end

      // Reset with random D-stage activity.
      reset = 1'b0;
      set_d(4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
      CondExE = 1'b1; FlushE = 1'b1; StallD = 1'b1;
      repeat (3) tick();
      chk("rst_wa3e", 16'(WA3E), 16'd15);
      chk("rst_wa3m", 16'(WA3M), 16'd15);
      chk("rst_wa3w", 16'(WA3W), 16'd15);
      chk("rst_ra1e", 16'(RA1E), 16'd15);
      chk("rst_ctrl", 16'({RegWriteM, RegWriteW, MemtoRegE, PCSrcE, PCSrcM, PCSrcW,
                           BranchTakenE}), 16'd0);
      chk("rst_match", 16'({Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E}), 16'd0);
      chk("rst_ldc", LdStallCnt, 16'd0);
      chk("rst_flc", FlushCnt, 16'd0);

      // Producer then consumer of r3: forwarded from M, then from W.
      @(negedge clk);
      reset = 1'b1; CondExE = 1'b1; FlushE = 1'b0; StallD = 1'b0;
      set_d(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_d(4'd3, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("fwd_m12de", 16'(Match_12D_E), 16'd1);
      tick();
      chk("fwd_m1em", 16'(Match_1E_M), 16'd1);
      chk("fwd_rwm", 16'(RegWriteM), 16'd1);
      set_d(4'd3, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("fwd_m1ew", 16'(Match_1E_W), 16'd1);
      chk("fwd_rww", 16'(RegWriteW), 16'd1);
      chk("fwd_m1em_off", 16'(Match_1E_M), 16'd0);

      // Load in E with a dependent op in D, then bubble E.
      set_d(4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_d(4'd0, 4'd5, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("ld_m12de", 16'(Match_12D_E), 16'd1);
      chk("ld_m2re", 16'(MemtoRegE), 16'd1);
      FlushE = 1'b1;
      tick();
      FlushE = 1'b0;
      chk("fl_wa3e", 16'(WA3E), 16'd15);
      chk("fl_m2re", 16'(MemtoRegE), 16'd0);
      chk("fl_m12de", 16'(Match_12D_E), 16'd0);
      chk("fl_cnt", FlushCnt, 16'd1);

      // Failed condition suppresses PC write, branch and register write.
      set_d(4'd0, 4'd0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      chk("cond1_pcse", 16'(PCSrcE), 16'd1);
      chk("cond1_bte", 16'(BranchTakenE), 16'd1);
      CondExE = 1'b0;
      set_d(4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("cond0_pcse", 16'(PCSrcE), 16'd0);
      chk("cond0_bte", 16'(BranchTakenE), 16'd0);
      tick();
      chk("cond0_rwm", 16'(RegWriteM), 16'd0);
      chk("cond0_pcsm", 16'(PCSrcM), 16'd0);
      CondExE = 1'b1;

      // PC as destination is never reported as a match.
      set_d(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_d(4'd15, 4'd15, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("pc_m12de", 16'(Match_12D_E), 16'd0);
      tick();
      chk("pc_m1em", 16'(Match_1E_M), 16'd0);
      chk("pc_m2em", 16'(Match_2E_M), 16'd0);
      tick();
      chk("pc_m1ew", 16'(Match_1E_W), 16'd0);

      // Table-driven run from a fresh reset, expectations through the scoreboard queue.
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      for (int k = 0; k < NVec; k++) begin
         apply(vecs[k].i);
         exp_q.push_back(vecs[k].e);
         tick();
         if (exp_q.size() == 0) begin
            chk("sb_empty", 16'd0, 16'd1);
         end else begin
            exp_o = exp_q.pop_front();
            chk_all($sformatf("vec%0d", k), exp_o);
         end
         @(negedge clk);
      end

      // Stall counter saturation and asynchronous clear.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1; FlushE = 1'b0; StallD = 1'b1;
      repeat (65534) @(posedge clk);
      #1 chk("sat_fffe", LdStallCnt, 16'hFFFE);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("sat_hold%0d", k), LdStallCnt, 16'hFFFF);
      end
      #2 reset = 1'b0;
      #1 chk("async_ldc", LdStallCnt, 16'd0);
      chk("async_flc", FlushCnt, 16'd0);
      chk("async_wa3e", 16'(WA3E), 16'd15);
      StallD = 1'b0;
      @(negedge clk) reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
